// File: rtl/evdb_beat_serializer_pkg.sv
// Shared evict-path types and widths for the evict data buffer serializer.
package evdb_beat_serializer_pkg;

  localparam int unsigned BUS_WIDTH            = 128;
  localparam int unsigned OFFSET_WIDTH         = 9;
  localparam int unsigned INDEX_WIDTH          = 8;
  localparam int unsigned TAG_WIDTH            = 20;
  localparam int unsigned MSHR_ENTRY_IDX_WIDTH = 4;
  localparam int unsigned DB_ENTRY_IDX_WIDTH   = 4;
  localparam int unsigned TXNID_WIDTH          = 8;
  localparam int unsigned SIDEBAND_WIDTH       = 4;
  localparam int unsigned EVDB_LINE_WIDTH      = 1024;
  localparam int unsigned EVDB_BEATS           = 1024 / BUS_WIDTH;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
  } addr_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]            tag;
    logic [INDEX_WIDTH-1:0]          index;
    logic [OFFSET_WIDTH-1:0]         offset;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
  } arb_out_req_t;

  typedef struct packed {
    arb_out_req_t                evict_req_pld;
    logic [EVDB_LINE_WIDTH-1:0]  data;
  } ram_to_evdb_pld_t;

  typedef struct packed {
    addr_t                           addr;
    logic [BUS_WIDTH-1:0]            data;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
    logic                            last;
  } evict_to_ds_pld_t;

endpackage

// File: rtl/evdb_line_fifo.sv
// DEPTH-entry valid/ready line FIFO exposing the head entry and a pop strobe.
module evdb_line_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push_vld,
  output logic push_rdy,
  input  T     push_data,
  output logic head_vld,
  output T     head_data,
  input  logic pop
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // No pass-through: a full buffer stays not-ready even while popping.
  assign push_rdy  = !rst && (count != CNT_W'(DEPTH));
  assign head_vld  = (count != '0);
  assign head_data = mem[rd_ptr];
  assign do_push   = push_vld && push_rdy;
  assign do_pop    = pop && head_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/evdb_beat_serializer.sv
// Evict data buffer output stage: buffers lines and emits BUS_W-wide beats.
// Optional per-line completion pulse enabled by macro EVDB_DONE_EN.
module evdb_beat_serializer
  import evdb_beat_serializer_pkg::*;
#(
  parameter int unsigned LINE_W = 1024,
  parameter int unsigned BUS_W  = BUS_WIDTH,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_vld,
  output logic                            in_rdy,
  input  ram_to_evdb_pld_t                in_pld,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output evict_to_ds_pld_t                out_pld,
  output logic                            done_vld,
  output logic [MSHR_ENTRY_IDX_WIDTH-1:0] done_rob_entry_id,
  output logic [DB_ENTRY_IDX_WIDTH-1:0]   done_db_entry_id
);

  localparam int unsigned BEATS  = LINE_W / BUS_W;
  localparam int unsigned BEAT_W = $clog2(BEATS);

  ram_to_evdb_pld_t  head;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BUS_W-1:0]  beat_data;
  logic              last_beat;
  logic              beat_hs;
  logic              line_pop;

  evdb_line_fifo #(
    .DEPTH (DEPTH),
    .T     (ram_to_evdb_pld_t)
  ) u_line_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (in_vld),
    .push_rdy  (in_rdy),
    .push_data (in_pld),
    .head_vld  (out_vld),
    .head_data (head),
    .pop       (line_pop)
  );

  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  assign beat_hs   = out_vld && out_rdy;
  assign line_pop  = beat_hs && last_beat;

  always_ff @(posedge clk) begin
    if (rst)          beat_cnt <= '0;
    else if (beat_hs) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
  end

  always_comb begin
    beat_data = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat_cnt == BEAT_W'(b)) beat_data = head.data[b*BUS_W +: BUS_W];
    end
  end

  always_comb begin
    out_pld              = '0;
    out_pld.addr.tag     = head.evict_req_pld.tag;
    out_pld.addr.index   = head.evict_req_pld.index;
    out_pld.addr.offset  = head.evict_req_pld.offset
                         + OFFSET_WIDTH'(beat_cnt) * OFFSET_WIDTH'(BUS_W / 8);
    out_pld.data         = beat_data;
    out_pld.rob_entry_id = head.evict_req_pld.rob_entry_id;
    out_pld.db_entry_id  = head.evict_req_pld.db_entry_id;
    out_pld.txnid        = head.evict_req_pld.txnid;
    out_pld.sideband     = head.evict_req_pld.sideband;
    out_pld.last         = last_beat;
  end

`ifdef EVDB_DONE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      done_vld          <= 1'b0;
      done_rob_entry_id <= '0;
      done_db_entry_id  <= '0;
    end else begin
      done_vld          <= line_pop;
      done_rob_entry_id <= line_pop ? head.evict_req_pld.rob_entry_id : '0;
      done_db_entry_id  <= line_pop ? head.evict_req_pld.db_entry_id  : '0;
    end
  end
`else
  assign done_vld          = 1'b0;
  assign done_rob_entry_id = '0;
  assign done_db_entry_id  = '0;
`endif

endmodule
